muldiv_ctrl_unit: RTL and testbench
===================================

Name: muldiv_ctrl_unit

Overview:
- Multi-cycle RV32M execution controller. Decodes {funct7, funct3, opcode} and runs an iterative shift-add multiplier or restoring divider over XLEN cycles.
- Sits beside the main ALU in the multi-cycle CPU. The CPU FSM holds in its EX state while busy=1 and writes result back on done.
- Generalises ALU-op decode to a parametrised, sequential M-extension unit with start/busy/done handshake.

Parameters:
XLEN, 32, operand/result width; must be even and at least 8

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request strobe; sampled only in IDLE
part_of_inst  in  17  {funct7[16:10], funct3[9:7], opcode[6:0]}
rs1_data  in  XLEN  operand A (multiplicand / dividend)
rs2_data  in  XLEN  operand B (multiplier / divisor)
busy  out  1  high from accept edge until done cycle inclusive
done  out  1  one-cycle pulse; result valid
result  out  XLEN  final value; held until next accept
illegal  out  1  one-cycle pulse: start with non-M encoding

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE; busy, done, illegal=0; result=0; internal accumulators and counters cleared. No done is produced for an aborted operation.
- Accept condition: state==IDLE, start=1, opcode==0110011, funct7==0000001. Operands, funct3 and sign flags are latched on the accept edge. Later input changes are ignored.
- Rejected start:
  - Start in IDLE with any other encoding: illegal=1 on the next cycle only; state stays IDLE; result unchanged.
  - Start while busy: ignored, no pulse.
- funct3 decode:
  - 000 MUL: low XLEN bits of product.
  - 001 MULH: high half, signed x signed.
  - 010 MULHSU: high half, signed x unsigned.
  - 011 MULHU: high half, unsigned x unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- States: IDLE -> MUL | DIV | DONE(special) ; MUL/DIV -> FIX -> DONE -> IDLE.
  - MUL/DIV: operate on magnitudes (2*XLEN-bit product or XLEN-bit quotient/remainder). One bit per cycle; counter runs XLEN-1 down to 0.
  - FIX: apply sign. Product sign = sA^sB. Quotient sign = sA^sB. Remainder sign = sA. Select the requested half or field.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle after the (XLEN+2)th rising edge following the accept edge, i.e. 34 cycles for XLEN=32.
- Special cases are decided at accept and jump straight to DONE, so done comes 1 edge after accept:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM, A = most-negative, B = -1): quotient = A; remainder = 0.
- Back-to-back operation: start may be asserted in the DONE cycle but is not accepted. Acceptance is possible in the following IDLE cycle at the earliest.
- Arithmetic: all internal math is unsigned on magnitudes. The negation of the most-negative value wraps to itself, which is correct as an unsigned magnitude.

Optional Feature:
SINGLE_CYCLE_MUL_EN
- Defined: multiply ops use a combinational 2*XLEN product. IDLE -> FIX -> DONE, so done is 2 edges after accept. Divide path is unchanged.
- Undefined: iterative multiplier with XLEN+2 latency as above. Both builds must produce bit-identical results.

Decomposition:
- Shared package/header holds the opcode ARITHMETIC (0110011), FUNCT7_MULDIV (0000001), the eight funct3 codes, and the state encoding (3-bit: IDLE, MUL, DIV, FIX, DONE).
- One natural sub-module: muldiv_iter_core. It is the shift/add-subtract datapath with load/step/fix controls. muldiv_ctrl_unit keeps the FSM, decode, special-case detection and handshake.

Test Plan:
- MUL: 7 x 0xFFFFFFFD -> done at edge 34, result=0xFFFFFFEB, busy high for 34 cycles. With SINGLE_CYCLE_MUL_EN, done at edge 2.
- MULH/MULHU: 0x80000000 x 0x80000000 -> MULH=0x40000000, MULHU=0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV/REM: -7 / 2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF. DIVU 100 / 7 -> 14; REMU -> 2.
- Specials: DIV 5 / 0 -> 0xFFFFFFFF at edge 1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Handshake: start with funct7=0000000 -> illegal pulse 1 cycle, busy stays 0. Start re-pulsed mid-MUL with new operands -> ignored, original result returned.
- Reset: drive reset low at edge 10 of a DIVU -> busy=0, result=0 immediately, no done. A fresh DIVU after release completes normally.

Source files
------------

// File: rtl/muldiv_ctrl_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: instruction fields and FSM states.
// Optional build macro SINGLE_CYCLE_MUL_EN is consumed by muldiv_ctrl_unit and muldiv_iter_core.
package muldiv_ctrl_unit_pkg;

  localparam logic [6:0] OPC_ARITHMETIC = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Magnitude datapath: shift-add multiplier / restoring divider sharing one 2*XLEN accumulator.
// With SINGLE_CYCLE_MUL_EN defined, a multiply load captures the full product directly.
module muldiv_iter_core
  import muldiv_ctrl_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic            set_special,
  input  logic            is_div,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  input  logic [XLEN-1:0] special_value,
  input  logic            neg_res,
  input  logic            sel_hi,
  input  logic            sel_rem,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   op_q, op_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   fix_value;

  // Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend->quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? op_q : {XLEN{1'b0}})};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, op_q};
    div_ge    = (div_shift >= {1'b0, op_q});
    div_next  = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod_fix  = neg_res ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    div_raw   = sel_rem ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    fix_value = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    if (is_div) begin
      fix_value = neg_res ? (~div_raw + XLEN'(1)) : div_raw;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    op_d     = op_q;
    result_d = result_q;
    if (load) begin
      op_d  = is_div ? mag_b : mag_a;
      acc_d = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
`ifdef SINGLE_CYCLE_MUL_EN
      if (!is_div) begin
        acc_d = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
      end
`endif
    end else if (step) begin
      acc_d = is_div ? div_next : mul_next;
    end
    if (fix) begin
      result_d = fix_value;
    end else if (set_special) begin
      result_d = special_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_ctrl_unit.sv
// RV32M execution controller: decode, special-case detection, start/busy/done handshake and FSM.
// Build macro SINGLE_CYCLE_MUL_EN routes multiplies IDLE -> FIX -> DONE.
module muldiv_ctrl_unit
  import muldiv_ctrl_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [16:0]     part_of_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN);

`ifdef SINGLE_CYCLE_MUL_EN
  localparam state_e MUL_ENTRY = ST_FIX;
`else
  localparam state_e MUL_ENTRY = ST_MUL;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             illegal_q, illegal_d;

  logic            is_m;
  logic            sa, sb;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  logic core_load, core_step, core_fix, core_special, core_is_div;
  logic neg_res, sel_hi, sel_rem;

  assign opcode = part_of_inst[6:0];
  assign funct3 = part_of_inst[9:7];
  assign funct7 = part_of_inst[16:10];

  always_comb begin
    is_m     = (opcode == OPC_ARITHMETIC) && (funct7 == FUNCT7_MULDIV);
    sa       = a_is_signed(funct3) & rs1_data[XLEN-1];
    sb       = b_is_signed(funct3) & rs2_data[XLEN-1];
    mag_a    = sa ? (~rs1_data + XLEN'(1)) : rs1_data;
    mag_b    = sb ? (~rs2_data + XLEN'(1)) : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    // funct3[1] separates remainder from quotient within the divide group.
    if (div_zero) begin
      special_val = funct3[1] ? rs1_data : '1;
    end else begin
      special_val = funct3[1] ? '0 : rs1_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    illegal_d    = 1'b0;
    core_load    = 1'b0;
    core_step    = 1'b0;
    core_fix     = 1'b0;
    core_special = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_m) begin
            f3_d  = funct3;
            sa_d  = sa;
            sb_d  = sb;
            cnt_d = CNT_W'(XLEN-1);
            if (div_zero || div_ovf) begin
              core_special = 1'b1;
              state_d      = ST_DONE;
            end else begin
              core_load = 1'b1;
              state_d   = funct3[2] ? ST_DIV : MUL_ENTRY;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        core_fix = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      illegal_q <= illegal_d;
    end
  end

  // Remainder takes the dividend's sign; products and quotients take sA^sB.
  always_comb begin
    core_is_div = (state_q == ST_IDLE) ? funct3[2] : f3_q[2];
    neg_res     = (f3_q[2] && f3_q[1]) ? sa_q : (sa_q ^ sb_q);
    sel_hi      = (f3_q[1:0] != 2'b00);
    sel_rem     = f3_q[1];
  end

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (core_load),
    .step         (core_step),
    .fix          (core_fix),
    .set_special  (core_special),
    .is_div       (core_is_div),
    .mag_a        (mag_a),
    .mag_b        (mag_b),
    .special_value(special_val),
    .neg_res      (neg_res),
    .sel_hi       (sel_hi),
    .sel_rem      (sel_rem),
    .result       (result)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_ctrl_unit.sv
// Scoreboard bench for muldiv_ctrl_unit: directed vectors queue expected results, a monitor checks on done.
module tb_muldiv_ctrl_unit;

  localparam int XLEN = 32;
`ifdef SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 1;

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7M = 7'b0000001;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [16:0]     part_of_inst = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            busy, done, illegal;
  logic [XLEN-1:0] result;

  muldiv_ctrl_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .part_of_inst(part_of_inst),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [31:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;

  // Monitor: counts busy cycles and checks each done against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got result=%h, no transaction was outstanding", result);
        end else begin
          mon_e = sb.pop_front();
          if (result !== mon_e.res || busy_cnt != mon_e.lat) begin
            n_bad++;
            $display("FAIL %s: got result=%h busy=%0d cycles, required result=%h busy=%0d cycles",
                     mon_e.nm, result, busy_cnt, mon_e.res, mon_e.lat);
          end else begin
            $display("ok   %s: result=%h busy=%0d cycles", mon_e.nm, result, busy_cnt);
          end
        end
      end
      if (!busy) busy_cnt = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive_start(input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    part_of_inst = {f7, f3, OPC};
    rs1_data     = a;
    rs2_data     = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    rs1_data     = 32'hDEAD_BEEF;
    rs2_data     = 32'h1234_5678;
    part_of_inst = '0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", nm, busy, k);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] req, input int lat);
    sb.push_back('{nm, req, lat});
    drive_start(F7M, f3, a, b);
    wait_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_result", result, 32'd0);

    run_op("MUL_7xFFFFFFFD", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("MULH_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("MULHU_2p31_2p31", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("MULHSU_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("MUL_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MUL_LAT);
    run_op("DIV_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("REM_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("DIVU_100_7", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("REMU_100_7", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);

    // Illegal encoding: one-cycle pulse, no busy, result keeps the REMU value.
    drive_start(7'b0000000, 3'b000, 32'd3, 32'd4);
    check("illegal_pulse", {31'd0, illegal}, 32'd1);
    check("illegal_busy", {31'd0, busy}, 32'd0);
    check("illegal_result_held", result, 32'd2);
    @(negedge clk);
    check("illegal_cleared", {31'd0, illegal}, 32'd0);

    run_op("DIV_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    run_op("REM_5_0", 3'b110, 32'd5, 32'd0, 32'd5, SPC_LAT);
    run_op("DIV_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_op("REM_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPC_LAT);

    // Start re-pulsed while busy must be ignored; the original operation completes.
`ifdef SINGLE_CYCLE_MUL_EN
    sb.push_back('{"DIVU_repulse", 32'd14, DIV_LAT});
    drive_start(F7M, 3'b101, 32'd100, 32'd7);
`else
    sb.push_back('{"MUL_repulse", 32'hFFFF_FFEB, MUL_LAT});
    drive_start(F7M, 3'b000, 32'd7, 32'hFFFF_FFFD);
`endif
    repeat (4) @(negedge clk);
    drive_start(F7M, 3'b000, 32'd3, 32'd3);
    check("repulse_busy", {31'd0, busy}, 32'd1);
    wait_idle("repulse");

    // Abort a DIVU at edge 10 with reset; no done may follow.
    drive_start(F7M, 3'b101, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_op("DIVU_after_reset", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);

    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
